// File: rtl/op_result_encoder.sv
// ---------------------------------------------------------------------------
// op_result_encoder
//
// Return path of the decoded operation units. Each of the four op units
// (op0..op3) may hand over an 8-bit result at any time; the result is parked
// in a per-channel holding register. The holding registers are serialized
// onto a single VALID/READY output stream. CODE tells the consumer which op
// unit produced RESULT.
//
// Handshake: a result is transferred on every rising edge where VALID and
// READY are both high. While VALID is high and READY is low, VALID, CODE and
// RESULT are held stable and no new grant is made. A new grant may be made in
// the same cycle as a transfer, so the stream sustains one result per cycle.
//
// Parameters
//   WIDTH    data width of each op result and of RESULT
//   RR_MODE  1 = round-robin arbitration, 0 = fixed priority (op0 highest)
//
// Ports
//   CLK       in   rising-edge clock
//   RST       in   asynchronous, active-high reset
//   ENABLE    in   capture enable (draining continues while low)
//   REQ       in   per-channel capture request
//   R0..R3    in   results of op0..op3
//   BUSY      out  per-channel holding register occupied
//   VALID     out  RESULT/CODE valid
//   READY     in   downstream accept
//   CODE      out  index of the op that produced RESULT
//   RESULT    out  selected result
//   OVF       out  sticky: a request was dropped on a full channel
//   DONE_CNT  out  number of delivered results, wraps at 256
// ---------------------------------------------------------------------------
module op_result_encoder #(
    parameter int WIDTH   = 8,
    parameter bit RR_MODE = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic [3:0]       REQ,
    input  logic [WIDTH-1:0] R0,
    input  logic [WIDTH-1:0] R1,
    input  logic [WIDTH-1:0] R2,
    input  logic [WIDTH-1:0] R3,
    output logic [3:0]       BUSY,
    output logic             VALID,
    input  logic             READY,
    output logic [1:0]       CODE,
    output logic [WIDTH-1:0] RESULT,
    output logic             OVF,
    output logic [7:0]       DONE_CNT
);

    // Holding registers and output stage
    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       pend_q, pend_d;
    logic [1:0]       ptr_q;
    logic             valid_q;
    logic [1:0]       code_q;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q;
    logic [7:0]       done_q;

    // Arbitration / capture decode
    logic [WIDTH-1:0] r_in [4];
    logic             free;
    logic             gnt_any;
    logic [1:0]       gnt_idx;
    logic             found;
    logic [1:0]       idx;
    logic [3:0]       grant_vec;
    logic [3:0]       cap_req;
    logic [3:0]       accept;
    logic [3:0]       drop;

    always_comb begin
        r_in[0] = R0;
        r_in[1] = R1;
        r_in[2] = R2;
        r_in[3] = R3;
    end

    // The output register can take a new result when empty or draining now.
    assign free = ~valid_q | READY;

    always_comb begin
        found   = 1'b0;
        gnt_idx = 2'd0;
        idx     = 2'd0;
        if (RR_MODE) begin
            // Search starts just after the last winner; 2-bit add wraps mod 4.
            for (int k = 1; k <= 4; k++) begin
                idx = ptr_q + 2'(k);
                if (!found && pend_q[idx]) begin
                    found   = 1'b1;
                    gnt_idx = idx;
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!found && pend_q[k]) begin
                    found   = 1'b1;
                    gnt_idx = 2'(k);
                end
            end
        end
    end

    assign gnt_any   = free & found;
    assign grant_vec = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;

    // A full channel can still capture if its current entry leaves this cycle:
    // the old data goes out and the new data stays pending.
    assign cap_req = ENABLE ? REQ : 4'b0000;
    assign accept  = cap_req & (~pend_q | grant_vec);
    assign drop    = cap_req & ~accept;
    assign pend_d  = (pend_q & ~grant_vec) | accept;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) data_q[i] <= '0;
            pend_q   <= 4'b0000;
            ptr_q    <= 2'd3;
            valid_q  <= 1'b0;
            code_q   <= 2'd0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept[i]) data_q[i] <= r_in[i];
            end
            pend_q <= pend_d;

            if (gnt_any) begin
                valid_q  <= 1'b1;
                code_q   <= gnt_idx;
                result_q <= data_q[gnt_idx];
                ptr_q    <= gnt_idx;
            end else if (READY) begin
                valid_q  <= 1'b0;
            end

            if (|drop) ovf_q <= 1'b1;

            if (valid_q && READY) done_q <= done_q + 8'd1;
        end
    end

    assign BUSY     = pend_q;
    assign VALID    = valid_q;
    assign CODE     = code_q;
    assign RESULT   = result_q;
    assign OVF      = ovf_q;
    assign DONE_CNT = done_q;

endmodule

// File: tb/tb_op_result_encoder.sv
module tb_op_result_encoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ENABLE = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic [7:0] R0 = '0, R1 = '0, R2 = '0, R3 = '0;
  logic       READY = 1'b0;

  // a: round-robin instance, b: fixed-priority instance (same stimulus)
  logic [3:0] busy_a, busy_b;
  logic       valid_a, valid_b;
  logic [1:0] code_a, code_b;
  logic [7:0] result_a, result_b;
  logic       ovf_a, ovf_b;
  logic [7:0] done_a, done_b;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 CLK = ~CLK;

  op_result_encoder #(.WIDTH(8), .RR_MODE(1'b1)) dut_rr (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .REQ(REQ),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .BUSY(busy_a), .VALID(valid_a), .READY(READY), .CODE(code_a),
    .RESULT(result_a), .OVF(ovf_a), .DONE_CNT(done_a)
  );

  op_result_encoder #(.WIDTH(8), .RR_MODE(1'b0)) dut_fp (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .REQ(REQ),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .BUSY(busy_b), .VALID(valid_b), .READY(READY), .CODE(code_b),
    .RESULT(result_b), .OVF(ovf_b), .DONE_CNT(done_b)
  );

  // driver tasks: inputs change at negedge, outputs sampled at negedge
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    REQ = 4'b0000; ENABLE = 1'b1; READY = 1'b1;
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b exp 0", valid_a, valid_b); end
    checks++; if (busy_a !== 4'b0 || busy_b !== 4'b0) begin errors++; $display("FAIL reset_busy got %b/%b exp 0000", busy_a, busy_b); end
    checks++; if (code_a !== 2'd0 || result_a !== 8'h00 || ovf_a !== 1'b0 || done_a !== 8'd0) begin errors++; $display("FAIL reset_outs got code=%0d res=%h ovf=%b done=%0d exp 0", code_a, result_a, ovf_a, done_a); end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    ENABLE = 1'b1; READY = 1'b1; REQ = 4'b0001; R0 = 8'h2A;
    tick();
    REQ = 4'b0000;
    checks++; if (busy_a !== 4'b0001 || valid_a !== 1'b0) begin errors++; $display("FAIL basic_pend got busy=%b valid=%b exp 0001/0", busy_a, valid_a); end
    tick();
    checks++; if (valid_a !== 1'b1 || code_a !== 2'd0 || result_a !== 8'h2A) begin errors++; $display("FAIL basic_out got v=%b code=%0d res=%h exp 1/0/2a", valid_a, code_a, result_a); end
    checks++; if (result_b !== 8'h2A || busy_b !== 4'b0000) begin errors++; $display("FAIL basic_fp got res=%h busy=%b exp 2a/0000", result_b, busy_b); end
    tick();
    checks++; if (done_a !== 8'd1 || valid_a !== 1'b0) begin errors++; $display("FAIL basic_done got done=%0d v=%b exp 1/0", done_a, valid_a); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_res [4];
    logic [3:0] exp_busy [4];
    exp_res[0] = 8'h10; exp_res[1] = 8'h20; exp_res[2] = 8'h30; exp_res[3] = 8'h40;
    exp_busy[0] = 4'b1110; exp_busy[1] = 4'b1100; exp_busy[2] = 4'b1000; exp_busy[3] = 4'b0000;
    do_reset();
    REQ = 4'b1111; R0 = 8'h10; R1 = 8'h20; R2 = 8'h30; R3 = 8'h40;
    tick();
    REQ = 4'b0000;
    checks++; if (busy_a !== 4'b1111) begin errors++; $display("FAIL rr_pend got %b exp 1111", busy_a); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (valid_a !== 1'b1 || code_a !== 2'(i) || result_a !== exp_res[i] || busy_a !== exp_busy[i]) begin
        errors++; $display("FAIL rr_seq%0d got v=%b code=%0d res=%h busy=%b exp 1/%0d/%h/%b", i, valid_a, code_a, result_a, busy_a, i, exp_res[i], exp_busy[i]);
      end
    end
    tick();
    checks++; if (valid_a !== 1'b0 || done_a !== 8'd4) begin errors++; $display("FAIL rr_drain got v=%b done=%0d exp 0/4", valid_a, done_a); end
  endtask

  task automatic test_stall_ovf();
    do_reset();
    READY = 1'b0; REQ = 4'b0011; R0 = 8'h55; R1 = 8'h66;
    tick();
    REQ = 4'b0000;
    tick();
    checks++; if (valid_a !== 1'b1 || result_a !== 8'h55 || code_a !== 2'd0 || busy_a !== 4'b0010) begin errors++; $display("FAIL stall_first got v=%b res=%h code=%0d busy=%b exp 1/55/0/0010", valid_a, result_a, code_a, busy_a); end
    // channel 1 full and not granted: request dropped
    REQ = 4'b0010; R1 = 8'h99;
    tick();
    REQ = 4'b0000;
    checks++; if (ovf_a !== 1'b1 || ovf_b !== 1'b1) begin errors++; $display("FAIL stall_ovf got %b/%b exp 1", ovf_a, ovf_b); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (valid_a !== 1'b1 || result_a !== 8'h55 || code_a !== 2'd0 || busy_a !== 4'b0010 || done_a !== 8'd0) begin
        errors++; $display("FAIL stall_hold%0d got v=%b res=%h code=%0d busy=%b done=%0d exp 1/55/0/0010/0", i, valid_a, result_a, code_a, busy_a, done_a);
      end
    end
    READY = 1'b1;
    tick();
    checks++; if (valid_a !== 1'b1 || code_a !== 2'd1 || result_a !== 8'h66 || done_a !== 8'd1) begin errors++; $display("FAIL stall_ch1 got v=%b code=%0d res=%h done=%0d exp 1/1/66/1", valid_a, code_a, result_a, done_a); end
    tick();
    checks++; if (valid_a !== 1'b0 || ovf_a !== 1'b1 || done_a !== 8'd2) begin errors++; $display("FAIL stall_end got v=%b ovf=%b done=%0d exp 0/1/2", valid_a, ovf_a, done_a); end
  endtask

  task automatic test_fixed_priority();
    logic [7:0] exp_res [5];
    logic [1:0] exp_code [5];
    do_reset();
    REQ = 4'b1010; R1 = 8'h11; R3 = 8'h33;
    tick();
    REQ = 4'b0000;
    tick();
    checks++; if (code_b !== 2'd1 || result_b !== 8'h11) begin errors++; $display("FAIL fp_first got code=%0d res=%h exp 1/11", code_b, result_b); end
    tick();
    checks++; if (code_b !== 2'd3 || result_b !== 8'h33) begin errors++; $display("FAIL fp_second got code=%0d res=%h exp 3/33", code_b, result_b); end
    tick();
    // channel 1 re-requested every cycle keeps winning over channel 3
    REQ = 4'b1010; R1 = 8'h21; R3 = 8'h43;
    tick();
    exp_res[0] = 8'h21; exp_res[1] = 8'h22; exp_res[2] = 8'h23; exp_res[3] = 8'h24; exp_res[4] = 8'h43;
    exp_code[0] = 2'd1; exp_code[1] = 2'd1; exp_code[2] = 2'd1; exp_code[3] = 2'd1; exp_code[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin REQ = 4'b0010; R1 = 8'h22 + 8'(i); end
      else REQ = 4'b0000;
      tick();
      checks++; if (valid_b !== 1'b1 || code_b !== exp_code[i] || result_b !== exp_res[i]) begin
        errors++; $display("FAIL fp_starve%0d got v=%b code=%0d res=%h exp 1/%0d/%h", i, valid_b, code_b, result_b, exp_code[i], exp_res[i]);
      end
    end
    REQ = 4'b0000;
    tick();
    checks++; if (ovf_b !== 1'b0 || busy_b !== 4'b0000 || done_b !== 8'd7) begin errors++; $display("FAIL fp_end got ovf=%b busy=%b done=%0d exp 0/0000/7", ovf_b, busy_b, done_b); end
  endtask

  task automatic test_grant_capture();
    do_reset();
    REQ = 4'b0100; R2 = 8'h50;
    tick();
    REQ = 4'b0100; R2 = 8'h77;
    tick();
    REQ = 4'b0000;
    checks++; if (result_a !== 8'h50 || code_a !== 2'd2 || busy_a !== 4'b0100) begin errors++; $display("FAIL gc_old got res=%h code=%0d busy=%b exp 50/2/0100", result_a, code_a, busy_a); end
    tick();
    checks++; if (valid_a !== 1'b1 || code_a !== 2'd2 || result_a !== 8'h77 || busy_a !== 4'b0000) begin errors++; $display("FAIL gc_new got v=%b code=%0d res=%h busy=%b exp 1/2/77/0000", valid_a, code_a, result_a, busy_a); end
    checks++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0 || result_b !== 8'h77) begin errors++; $display("FAIL gc_ovf got ovf=%b/%b res_fp=%h exp 0/0/77", ovf_a, ovf_b, result_b); end
    tick();
  endtask

  task automatic test_enable();
    do_reset();
    ENABLE = 1'b0; REQ = 4'b0001; R0 = 8'hC1;
    tick();
    checks++; if (busy_a !== 4'b0000 || ovf_a !== 1'b0) begin errors++; $display("FAIL en_ignore got busy=%b ovf=%b exp 0000/0", busy_a, ovf_a); end
    ENABLE = 1'b1; R0 = 8'hC2;
    tick();
    ENABLE = 1'b0; R0 = 8'hC3;
    tick();
    REQ = 4'b0000;
    checks++; if (valid_a !== 1'b1 || result_a !== 8'hC2 || busy_a !== 4'b0000 || ovf_a !== 1'b0) begin errors++; $display("FAIL en_drain got v=%b res=%h busy=%b ovf=%b exp 1/c2/0000/0", valid_a, result_a, busy_a, ovf_a); end
    ENABLE = 1'b1;
    tick();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    READY = 1'b0; REQ = 4'b0111; R0 = 8'h01; R1 = 8'h02; R2 = 8'h03;
    tick();
    REQ = 4'b0000;
    tick();
    checks++; if (valid_a !== 1'b1 || busy_a !== 4'b0110) begin errors++; $display("FAIL mid_setup got v=%b busy=%b exp 1/0110", valid_a, busy_a); end
    RST = 1'b1;
    #1;
    checks++; if (valid_a !== 1'b0 || busy_a !== 4'b0 || code_a !== 2'd0 || result_a !== 8'h00 || done_a !== 8'd0) begin
      errors++; $display("FAIL mid_async got v=%b busy=%b code=%0d res=%h done=%0d exp all 0", valid_a, busy_a, code_a, result_a, done_a);
    end
    checks++; if (valid_b !== 1'b0 || busy_b !== 4'b0 || result_b !== 8'h00) begin errors++; $display("FAIL mid_async_fp got v=%b busy=%b res=%h exp 0", valid_b, busy_b, result_b); end
    @(negedge CLK);
    RST = 1'b0; READY = 1'b1;
    REQ = 4'b1111; R0 = 8'hA0; R1 = 8'hA1; R2 = 8'hA2; R3 = 8'hA3;
    tick();
    REQ = 4'b0000;
    tick();
    checks++; if (code_a !== 2'd0 || result_a !== 8'hA0 || code_b !== 2'd0) begin errors++; $display("FAIL mid_first got code=%0d/%0d res=%h exp 0/0/a0", code_a, code_b, result_a); end
  endtask

  task automatic test_done_wrap();
    do_reset();
    READY = 1'b1; REQ = 4'b0001; R0 = 8'h5A;
    // capture edge 1, first grant edge 2, transfers counted from edge 3 on
    repeat (257) tick();
    checks++; if (done_a !== 8'd255 || done_b !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d/%0d exp 255", done_a, done_b); end
    tick();
    checks++; if (done_a !== 8'd0 || done_b !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d/%0d exp 0", done_a, done_b); end
    checks++; if (ovf_a !== 1'b0 || valid_a !== 1'b1 || result_a !== 8'h5A) begin errors++; $display("FAIL wrap_stream got ovf=%b v=%b res=%h exp 0/1/5a", ovf_a, valid_a, result_a); end
    REQ = 4'b0000;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_stall_ovf();
    test_fixed_priority();
    test_grant_capture();
    test_enable();
    test_reset_midstream();
    test_done_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
